// File: rtl/ctrl_req_scheduler.sv
// Request scheduler: separate read/write FIFOs, direction batching by watermarks, per-bank
// open-row tracking in front of the ACT stage. Define STARVE_EN for the forced-switch guard.
module ctrl_req_scheduler #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned BA_W     = 2,
  parameter int unsigned ROW_W    = 16,
  parameter int unsigned COL_W    = 10,
  parameter int unsigned WR_HI_WM = 6,
  parameter int unsigned WR_LO_WM = 2
`ifdef STARVE_EN
  ,
  parameter int unsigned STARVE_MAX = 32
`endif
) (
  input  logic             CK_t,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_rw,
  input  logic [BA_W-1:0]  req_bank,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  output logic             iss_valid,
  input  logic             iss_ack,
  output logic             iss_hit,
  output logic [2:0]       iss_rw,
  output logic [BA_W-1:0]  iss_bank,
  output logic [ROW_W-1:0] iss_row,
  output logic [COL_W-1:0] iss_col,
  output logic             pre_valid,
  input  logic             pre_ack,
  output logic             wr_mode
);

  // Request encoding: RD_R=0, RDA_R=1, WR_R=2, WRA_R=3; other codes go to the read queue.
  localparam logic [2:0] RDA_R = 3'd1;
  localparam logic [2:0] WR_R  = 3'd2;
  localparam logic [2:0] WRA_R = 3'd3;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int          NB = 1 << BA_W;
  localparam int unsigned EW = 3 + BA_W + ROW_W + COL_W;

  typedef enum logic [1:0] {SCH_IDLE, SCH_CHECK, SCH_PRE, SCH_ISSUE} state_e;
  state_e state;

  logic [EW-1:0]    rd_mem [DEPTH];
  logic [EW-1:0]    wr_mem [DEPTH];
  logic [PW-1:0]    rd_wp, rd_rp, wr_wp, wr_rp;
  logic [CW-1:0]    rd_cnt, wr_cnt;
  logic             req_is_wr, rd_full, wr_full;
  logic             push_rd, push_wr, pop_rd, pop_wr;
  logic [EW-1:0]    req_entry, head;
  logic             mode_nxt, sel_nonempty, force_sw;
  logic [NB-1:0]    open_bits;
  logic [ROW_W-1:0] open_row [NB];

`ifdef STARVE_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;
  logic          other_nonempty;
`endif

  assign req_is_wr = (req_rw == WR_R) || (req_rw == WRA_R);
  assign rd_full   = (rd_cnt == CW'(DEPTH));
  assign wr_full   = (wr_cnt == CW'(DEPTH));
  assign req_ready = reset_n && (req_is_wr ? !wr_full : !rd_full);
  assign push_rd   = req_valid && req_ready && !req_is_wr;
  assign push_wr   = req_valid && req_ready && req_is_wr;
  // wr_mode is frozen from the IDLE latch until the pop, so it names the source queue.
  assign pop_rd    = (state == SCH_ISSUE) && iss_ack && !wr_mode;
  assign pop_wr    = (state == SCH_ISSUE) && iss_ack && wr_mode;
  assign req_entry = {req_rw, req_bank, req_row, req_col};

  always_comb begin
    mode_nxt = wr_mode;
    force_sw = 1'b0;
`ifdef STARVE_EN
    force_sw = (starve_cnt >= SW'(STARVE_MAX));
`endif
    if (force_sw) begin
      mode_nxt = !wr_mode;
    end else if (!wr_mode) begin
      if (wr_cnt >= CW'(WR_HI_WM) || (rd_cnt == '0 && wr_cnt != '0)) mode_nxt = 1'b1;
    end else if (wr_cnt == '0 || (wr_cnt <= CW'(WR_LO_WM) && rd_cnt != '0)) begin
      mode_nxt = 1'b0;
    end
    head         = mode_nxt ? wr_mem[wr_rp] : rd_mem[rd_rp];
    sel_nonempty = mode_nxt ? (wr_cnt != '0) : (rd_cnt != '0);
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      rd_wp  <= '0;
      rd_rp  <= '0;
      wr_wp  <= '0;
      wr_rp  <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (push_rd) rd_wp <= rd_wp + PW'(1);
      if (pop_rd)  rd_rp <= rd_rp + PW'(1);
      if (push_wr) wr_wp <= wr_wp + PW'(1);
      if (pop_wr)  wr_rp <= wr_rp + PW'(1);
      rd_cnt <= rd_cnt + CW'(push_rd) - CW'(pop_rd);
      wr_cnt <= wr_cnt + CW'(push_wr) - CW'(pop_wr);
    end
  end

  always_ff @(posedge CK_t) begin
    if (push_rd) rd_mem[rd_wp] <= req_entry;
    if (push_wr) wr_mem[wr_wp] <= req_entry;
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SCH_IDLE;
      wr_mode   <= 1'b0;
      iss_valid <= 1'b0;
      iss_hit   <= 1'b0;
      pre_valid <= 1'b0;
      iss_rw    <= '0;
      iss_bank  <= '0;
      iss_row   <= '0;
      iss_col   <= '0;
      open_bits <= '0;
      for (int b = 0; b < NB; b++) open_row[b] <= '0;
    end else begin
      unique case (state)
        SCH_IDLE: begin
          wr_mode <= mode_nxt;
          if (sel_nonempty) begin
            {iss_rw, iss_bank, iss_row, iss_col} <= head;
            state <= SCH_CHECK;
          end
        end
        SCH_CHECK: begin
          if (open_bits[iss_bank] && (open_row[iss_bank] == iss_row)) begin
            iss_hit   <= 1'b1;
            iss_valid <= 1'b1;
            state     <= SCH_ISSUE;
          end else if (open_bits[iss_bank]) begin
            pre_valid <= 1'b1;
            state     <= SCH_PRE;
          end else begin
            iss_hit   <= 1'b0;
            iss_valid <= 1'b1;
            state     <= SCH_ISSUE;
          end
        end
        SCH_PRE: begin
          if (pre_ack) begin
            open_bits[iss_bank] <= 1'b0;
            pre_valid <= 1'b0;
            iss_hit   <= 1'b0;
            iss_valid <= 1'b1;
            state     <= SCH_ISSUE;
          end
        end
        SCH_ISSUE: begin
          if (iss_ack) begin
            iss_valid <= 1'b0;
            if (iss_rw == RDA_R || iss_rw == WRA_R) begin
              open_bits[iss_bank] <= 1'b0;
            end else begin
              open_bits[iss_bank] <= 1'b1;
              open_row[iss_bank]  <= iss_row;
            end
            state <= SCH_IDLE;
          end
        end
      endcase
    end
  end

`ifdef STARVE_EN
  assign other_nonempty = wr_mode ? (rd_cnt != '0) : (wr_cnt != '0);

  // Counts cycles the idle class waits while the other class is mid-request.
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (state == SCH_IDLE && mode_nxt != wr_mode) begin
      starve_cnt <= '0;
    end else if (state != SCH_IDLE && other_nonempty && starve_cnt < SW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_req_scheduler.sv
// Bench for ctrl_req_scheduler: directed vector table, hand-written batching/full/reset
// sequences, and random traffic checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_ctrl_req_scheduler;
  localparam int DEPTH = 8;
  localparam int HI    = 6;
  localparam int LO    = 2;
`ifdef STARVE_EN
  localparam int STARVE = 32;
`endif
  localparam logic [2:0] RD_R = 3'd0, RDA_R = 3'd1, WR_R = 3'd2, WRA_R = 3'd3;

  logic        CK_t = 1'b0, reset_n = 1'b0;
  logic        req_valid = 1'b0, iss_ack = 1'b0, pre_ack = 1'b0;
  logic [2:0]  req_rw = '0;
  logic [1:0]  req_bank = '0;
  logic [15:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        req_ready, iss_valid, iss_hit, pre_valid, wr_mode;
  logic [2:0]  iss_rw;
  logic [1:0]  iss_bank;
  logic [15:0] iss_row;
  logic [9:0]  iss_col;

  ctrl_req_scheduler dut (
    .CK_t(CK_t), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .iss_valid(iss_valid), .iss_ack(iss_ack), .iss_hit(iss_hit), .iss_rw(iss_rw),
    .iss_bank(iss_bank), .iss_row(iss_row), .iss_col(iss_col),
    .pre_valid(pre_valid), .pre_ack(pre_ack), .wr_mode(wr_mode)
  );

  always #5 CK_t = ~CK_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_wr(input logic [2:0] rw);
    return (rw == WR_R) || (rw == WRA_R);
  endfunction

  task automatic do_reset();
    @(negedge CK_t);
    req_valid = 0; iss_ack = 0; pre_ack = 0; reset_n = 0;
    repeat (2) @(negedge CK_t);
    reset_n = 1;
  endtask

  // Called at a negedge; the request is taken on the following rising edge.
  task automatic enq(input logic [2:0] rw, input logic [1:0] bank, input logic [15:0] row,
                     input logic [9:0] col);
    req_valid = 1; req_rw = rw; req_bank = bank; req_row = row; req_col = col;
    #1 check("enq ready", {63'd0, req_ready}, 64'd1);
    @(negedge CK_t);
    req_valid = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]  rw;
    logic [1:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
    logic        exp_hit;
    logic        exp_pre;
  } vec_t;

  task automatic apply_vec(input vec_t v, input int idx);
    int lat = 0;
    int pre_wait = 0;
    bit saw_pre = 0;
    @(negedge CK_t);
    req_valid = 1; req_rw = v.rw; req_bank = v.bank; req_row = v.row; req_col = v.col;
    iss_ack = 1; pre_ack = 0;
    #1 check($sformatf("v%0d req_ready", idx), {63'd0, req_ready}, 64'd1);
    @(negedge CK_t);
    req_valid = 0;
    for (int c = 1; c <= 20; c++) begin
      if (pre_valid) begin
        saw_pre = 1;
        pre_wait++;
        pre_ack = (pre_wait >= 4);
      end else begin
        pre_ack = 0;
      end
      if (iss_valid) begin
        lat = c;
        break;
      end
      @(negedge CK_t);
    end
    pre_ack = 0;
    check($sformatf("v%0d issued", idx), {63'd0, lat != 0}, 64'd1);
    check($sformatf("v%0d pre_valid seen", idx), {63'd0, saw_pre}, {63'd0, v.exp_pre});
    check($sformatf("v%0d iss_hit", idx), {63'd0, iss_hit}, {63'd0, v.exp_hit});
    check($sformatf("v%0d payload", idx), {33'd0, iss_rw, iss_bank, iss_row, iss_col},
          {33'd0, v.rw, v.bank, v.row, v.col});
    // Enqueue edge, IDLE latch edge, CHECK edge: valid seen at the third negedge.
    if (!v.exp_pre) check($sformatf("v%0d latency", idx), 64'(lat), 64'd3);
    @(negedge CK_t);
    check($sformatf("v%0d valid drops after ack", idx), {63'd0, iss_valid}, 64'd0);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0]  rw;
    logic [1:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
  } req_t;

  req_t        rd_q[$], wr_q[$];
  req_t        cur;
  bit          have_cur, cur_hit, cur_pre, pre_done, m_mode;
  bit          m_open[4];
  logic [15:0] m_row[4];
  int          m_starve;

  task automatic model_init();
    rd_q.delete(); wr_q.delete();
    have_cur = 0; m_mode = 0; m_starve = 0; pre_done = 0;
    for (int b = 0; b < 4; b++) begin
      m_open[b] = 0;
      m_row[b] = '0;
    end
  endtask

  task automatic step(input bit drain);
    req_t r;
    bit   rdy_exp, nm, legal;
    @(negedge CK_t);
    check("rnd wr_mode", {63'd0, wr_mode}, {63'd0, m_mode});
    if (iss_valid) begin
      legal = have_cur && (!cur_pre || pre_done);
      check("rnd iss_valid legal", {63'd0, legal}, 64'd1);
      if (have_cur) begin
        check("rnd payload", {33'd0, iss_rw, iss_bank, iss_row, iss_col}, {33'd0, cur});
        check("rnd iss_hit", {63'd0, iss_hit}, {63'd0, cur_hit});
      end
    end
    if (pre_valid) begin
      legal = have_cur && cur_pre && !pre_done;
      check("rnd pre_valid legal", {63'd0, legal}, 64'd1);
    end
    if (drain) begin
      req_valid = 0; iss_ack = 1; pre_ack = 1;
    end else begin
      r.rw = 3'($urandom_range(0, 3));
      r.bank = 2'($urandom_range(0, 3));
      r.row = 16'($urandom_range(0, 3));
      r.col = 10'($urandom_range(0, 1023));
      req_valid = ($urandom_range(0, 1) == 0);
      req_rw = r.rw; req_bank = r.bank; req_row = r.row; req_col = r.col;
      iss_ack = ($urandom_range(0, 2) != 0);
      pre_ack = ($urandom_range(0, 3) == 0);
    end
    #1;
    rdy_exp = is_wr(req_rw) ? (wr_q.size() < DEPTH) : (rd_q.size() < DEPTH);
    check("rnd req_ready", {63'd0, req_ready}, {63'd0, rdy_exp});
    // Effects of the coming rising edge.
    if (!have_cur) begin
      nm = m_mode;
`ifdef STARVE_EN
      if (m_starve >= STARVE) nm = !m_mode;
      else
`endif
      if (!m_mode && (wr_q.size() >= HI || (rd_q.size() == 0 && wr_q.size() > 0))) nm = 1;
      else if (m_mode && (wr_q.size() == 0 || (wr_q.size() <= LO && rd_q.size() > 0))) nm = 0;
      if (nm != m_mode) m_starve = 0;
      m_mode = nm;
      if (m_mode ? (wr_q.size() > 0) : (rd_q.size() > 0)) begin
        cur = m_mode ? wr_q[0] : rd_q[0];
        have_cur = 1;
        pre_done = 0;
        cur_hit = m_open[cur.bank] && (m_row[cur.bank] == cur.row);
        cur_pre = m_open[cur.bank] && !cur_hit;
      end
    end else begin
`ifdef STARVE_EN
      if ((m_mode ? rd_q.size() > 0 : wr_q.size() > 0) && m_starve < STARVE) m_starve++;
`endif
      if (pre_valid && pre_ack) begin
        pre_done = 1;
        m_open[cur.bank] = 0;
      end
      if (iss_valid && iss_ack) begin
        if (m_mode) void'(wr_q.pop_front());
        else void'(rd_q.pop_front());
        if (cur.rw == RDA_R || cur.rw == WRA_R) begin
          m_open[cur.bank] = 0;
        end else begin
          m_open[cur.bank] = 1;
          m_row[cur.bank] = cur.row;
        end
        have_cur = 0;
      end
    end
    if (req_valid && rdy_exp) begin
      r = '{rw: req_rw, bank: req_bank, row: req_row, col: req_col};
      if (is_wr(req_rw)) wr_q.push_back(r);
      else rd_q.push_back(r);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t       vecs[9];
    logic [9:0] wm_col[9];
    bit         wm_mode[9];
    bit         wm_hit[9];
    int         idx;
    bit         seen, bad;

    vecs[0] = '{RD_R,  2'd0, 16'd5, 10'd8, 1'b0, 1'b0};
    vecs[1] = '{RD_R,  2'd0, 16'd5, 10'd9, 1'b1, 1'b0};
    vecs[2] = '{RD_R,  2'd1, 16'd3, 10'd1, 1'b0, 1'b0};
    vecs[3] = '{RD_R,  2'd1, 16'd9, 10'd2, 1'b0, 1'b1};
    vecs[4] = '{RDA_R, 2'd2, 16'd4, 10'd3, 1'b0, 1'b0};
    vecs[5] = '{RD_R,  2'd2, 16'd4, 10'd4, 1'b0, 1'b0};
    vecs[6] = '{WR_R,  2'd0, 16'd5, 10'd5, 1'b1, 1'b0};
    vecs[7] = '{WRA_R, 2'd1, 16'd9, 10'd6, 1'b1, 1'b0};
    vecs[8] = '{WR_R,  2'd1, 16'd9, 10'd7, 1'b0, 1'b0};
    wm_col  = '{10'd0, 10'd10, 10'd11, 10'd12, 10'd13, 10'd1, 10'd2, 10'd14, 10'd15};
    wm_mode = '{0, 1, 1, 1, 1, 0, 0, 1, 1};
    wm_hit  = '{0, 1, 1, 1, 1, 1, 1, 1, 1};

    // Reset state.
    repeat (2) @(negedge CK_t);
    check("reset outputs", {53'd0, req_ready, iss_valid, iss_hit, pre_valid, wr_mode,
                            iss_rw, iss_bank}, 64'd0);
    check("reset payload", {38'd0, iss_row, iss_col}, 64'd0);
    reset_n = 1;

    for (int i = 0; i < 9; i++) apply_vec(vecs[i], i);

    // Watermark batching: R0 in flight, then 6 writes push the block into WRITE mode.
    do_reset();
    iss_ack = 0; pre_ack = 1;
    for (int i = 0; i < 3; i++) enq(RD_R, 2'd0, 16'd7, 10'(i));
    for (int i = 0; i < 6; i++) enq(WR_R, 2'd0, 16'd7, 10'(10 + i));
    iss_ack = 1;
    idx = 0;
    for (int c = 0; c < 200 && idx < 9; c++) begin
      if (iss_valid) begin
        check($sformatf("wm%0d col", idx), 64'(iss_col), 64'(wm_col[idx]));
        check($sformatf("wm%0d wr_mode", idx), {63'd0, wr_mode}, {63'd0, wm_mode[idx]});
        check($sformatf("wm%0d hit", idx), {63'd0, iss_hit}, {63'd0, wm_hit[idx]});
        idx++;
      end
      @(negedge CK_t);
    end
    check("wm issue count", 64'(idx), 64'd9);

    // Full read queue: reads back-pressured (even with a pop pending), writes still taken.
    do_reset();
    for (int i = 0; i < DEPTH; i++) enq(RD_R, 2'd0, 16'(i), 10'(i));
    req_valid = 1; req_rw = RD_R;
    #1 check("full rd ready", {63'd0, req_ready}, 64'd0);
    req_rw = WR_R;
    #1 check("full wr ready", {63'd0, req_ready}, 64'd1);
    req_rw = RD_R; iss_ack = 1;
    #1 check("full ready with pop", {63'd0, req_ready}, 64'd0);
    @(negedge CK_t);
    check("ready after pop", {63'd0, req_ready}, 64'd1);
    req_valid = 0;

    // Reset asserted while a precharge is outstanding.
    do_reset();
    iss_ack = 1; pre_ack = 0;
    enq(RD_R, 2'd3, 16'd1, 10'd0);
    enq(RD_R, 2'd3, 16'd2, 10'd1);
    enq(RD_R, 2'd0, 16'd0, 10'd2);
    enq(RD_R, 2'd0, 16'd0, 10'd3);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (pre_valid) seen = 1;
      else @(negedge CK_t);
    end
    check("pre before reset", {63'd0, seen}, 64'd1);
    #2 reset_n = 0;
    #1 check("reset mid-PRE outputs", {60'd0, pre_valid, iss_valid, req_ready, wr_mode}, 64'd0);
    @(negedge CK_t);
    reset_n = 1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CK_t);
      if (iss_valid || pre_valid) bad = 1;
    end
    check("queues empty after reset", {63'd0, bad}, 64'd0);
    check("ready after reset", {63'd0, req_ready}, 64'd1);

    // Random traffic against the reference model, then drain.
    do_reset();
    model_init();
    for (int c = 0; c < 4000; c++) step(1'b0);
    idx = 0;
    while (idx < 500 && (have_cur || rd_q.size() > 0 || wr_q.size() > 0)) begin
      step(1'b1);
      idx++;
    end
    check("drain completed", {63'd0, have_cur || rd_q.size() > 0 || wr_q.size() > 0}, 64'd0);
    step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ctrl_req_scheduler.md
Name: ctrl_req_scheduler

Overview:
Front-end scheduler for the ACT/CAS command path. It buffers host read/write requests in separate read and write queues and batches same-direction traffic to reduce read-to-write and write-to-read turnarounds. It tracks the open row per bank and presents one request at a time to the ACT stage, flagged as row-hit (no ACT) or row-miss (PRE then ACT). Sits between the host request interface and the burst ACT/CAS controllers.

Parameters:
DEPTH, 8, entries per queue (power of 2, >=4)
BA_W, 2, bank address width; banks = 2**BA_W
ROW_W, 16, row address width
COL_W, 10, column address width
WR_HI_WM, 6, write-queue count at or above which the block switches to WRITE mode
WR_LO_WM, 2, write-queue count at or below which WRITE mode may end
STARVE_MAX, 32, cycles the idle-class head may wait before a forced switch (STARVE_EN only)

Ports:
CK_t  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  host request accepted when valid&ready
req_rw  in  3  RD_R/RDA_R/WR_R/WRA_R (package encoding)
req_bank  in  BA_W  bank
req_row  in  ROW_W  row
req_col  in  COL_W  column
iss_valid  out  1  request presented to ACT stage
iss_ack  in  1  ACT stage accepted presented request
iss_hit  out  1  1 = row open, no ACT needed (no_act path); 0 = ACT needed
iss_rw  out  3  request type
iss_bank  out  BA_W  bank
iss_row  out  ROW_W  row
iss_col  out  COL_W  column
pre_valid  out  1  precharge request for iss_bank (row conflict)
pre_ack  in  1  precharge completed
wr_mode  out  1  1 = WRITE batch active

Behaviour:
- Reset (async, reset_n=0): all outputs 0; queues empty; all bank-open bits cleared; state SCH_IDLE; wr_mode=0; starve counter 0.
- Enqueue: req_ready = ~full of target queue (WR_R/WRA_R -> write queue, else read queue); combinational from req_rw. Full queue: req_ready=0 even if a dequeue occurs same cycle. Simultaneous enqueue/dequeue on a non-full queue: count unchanged. Pointers wrap modulo DEPTH; counts 0..DEPTH (log2(DEPTH)+1 bits).
- Mode select (evaluated in SCH_IDLE only): READ->WRITE when wr_cnt>=WR_HI_WM or (rd_cnt==0 and wr_cnt>0). WRITE->READ when wr_cnt==0 or (wr_cnt<=WR_LO_WM and rd_cnt>0). Never switches mid-request.
- FSM:
  SCH_IDLE: if selected queue non-empty, latch head into iss_* registers -> SCH_CHECK.
  SCH_CHECK (1 cycle): open[bank]&&row match -> iss_hit=1 -> SCH_ISSUE; open&&mismatch -> pre_valid=1 -> SCH_PRE; closed -> iss_hit=0 -> SCH_ISSUE.
  SCH_PRE: hold pre_valid until pre_ack; on ack clear open[bank], pre_valid=0, iss_hit=0 -> SCH_ISSUE.
  SCH_ISSUE: iss_valid=1, payload stable until iss_ack. On ack: pop head, iss_valid=0; RD_R/WR_R set open[bank]=1, open_row=iss_row; RDA_R/WRA_R clear open[bank] -> SCH_IDLE.
- Latency: request enqueued into empty queue, bank hit, iss_ack tied high -> iss_valid asserts 3 cycles after acceptance edge (enqueue, IDLE latch, CHECK).
- pre_ack/iss_ack outside their wait states are ignored.
- Queue order strictly FIFO within class; no reordering across same-class entries.
- Reset mid-operation: pending requests discarded, no further iss_valid/pre_valid.

Optional Feature:
STARVE_EN: when defined, a counter increments each cycle the non-selected class is non-empty and the selected class is being served; on reaching STARVE_MAX the next SCH_IDLE evaluation forces a mode switch and the counter clears. Counter clears on any mode switch. Without STARVE_EN, mode changes only by the watermark rules.

Test Plan:
- Single RD_R bank0 row5 col8 after reset, iss_ack=1 -> iss_valid 3 cycles later, iss_hit=0; then RD_R bank0 row5 -> iss_hit=1, no pre_valid.
- RD_R bank1 row3 then RD_R bank1 row9 -> second issues pre_valid; with pre_ack 4 cycles later, then iss_valid with iss_hit=0, iss_row=9.
- RDA_R bank2 row4 then RD_R bank2 row4 -> second has iss_hit=0, no pre_valid.
- 3 reads queued, 6 writes enqueued -> wr_mode=1 after current request, 4 writes issue until wr_cnt=2, then reads resume in order.
- Fill read queue with 8 requests, iss_ack=0 -> req_ready=0 for 9th RD_R, req_ready=1 for WR_R.
- STARVE_EN, STARVE_MAX=32: continuous reads, one write waiting -> write issues no later than first IDLE after 32 cycles; reset_n pulse mid-SCH_PRE -> pre_valid=0, queues empty.
